// File: rtl/uart_rx_param.sv
// Parametrised UART receiver (DATA_BITS data, none/even/odd parity, 1-2 stop bits).
// Define UART_RX_MAJORITY_EN for 2-of-3 majority bit decisions around each decision count.
module uart_rx_param #(
   parameter int unsigned CLKS_PER_BIT = 87,
   parameter int unsigned DATA_BITS    = 8,
   parameter int unsigned PARITY_MODE  = 0,
   parameter int unsigned STOP_BITS    = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 serial_data,
   output logic                 o_rx_dv,
   output logic [DATA_BITS-1:0] o_rx_data,
   output logic                 o_parity_err,
   output logic                 o_frame_err,
   output logic                 o_busy
);

   localparam int unsigned CW     = $clog2(CLKS_PER_BIT);
   localparam int unsigned IW     = $clog2(DATA_BITS + 1);
   localparam int unsigned H      = (CLKS_PER_BIT - 1) / 2;
   localparam bit          PAR_EN = (PARITY_MODE == 1) || (PARITY_MODE == 2);
   localparam bit          ODD    = (PARITY_MODE == 2);
   localparam logic [CW-1:0] CNT_MID = CW'(H);
   localparam logic [CW-1:0] CNT_END = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;

   state_t               state_q, state_d;
   logic                 sync_q, line_q;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [IW-1:0]        idx_q, idx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 par_q, par_d;
   logic                 perr_q, perr_d;
   logic                 ferr_q, ferr_d;
   logic                 dv_q, dv_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 pe_q, pe_d;
   logic                 fe_q, fe_d;
   logic                 bit_s;

`ifdef UART_RX_MAJORITY_EN
   logic [1:0] hist_q;

   always_ff @(posedge clk) begin
      if (reset) hist_q <= '1;
      else       hist_q <= {hist_q[0], line_q};
   end

   assign bit_s = (line_q & hist_q[0]) | (line_q & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
   assign bit_s = line_q;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      par_d   = par_q;
      perr_d  = perr_q;
      ferr_d  = ferr_q;
      dv_d    = 1'b0;
      data_d  = data_q;
      pe_d    = pe_q;
      fe_d    = fe_q;
      unique case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            idx_d = '0;
            if (!line_q) state_d = S_START;
         end
         S_START: begin
            if (cnt_q == CNT_MID) begin
               cnt_d   = '0;
               state_d = bit_s ? S_IDLE : S_DATA;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DATA: begin
            if (cnt_q == CNT_END) begin
               cnt_d   = '0;
               // LSB-first: after DATA_BITS shifts the first bit sits at bit 0
               shift_d = {bit_s, shift_q[DATA_BITS-1:1]};
               par_d   = par_q ^ bit_s;
               if (idx_q == IW'(DATA_BITS - 1)) begin
                  idx_d   = '0;
                  state_d = PAR_EN ? S_PARITY : S_STOP;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_PARITY: begin
            if (cnt_q == CNT_END) begin
               cnt_d   = '0;
               perr_d  = ODD ? ~(par_q ^ bit_s) : (par_q ^ bit_s);
               idx_d   = '0;
               state_d = S_STOP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_STOP: begin
            if (cnt_q == CNT_END) begin
               cnt_d = '0;
               if (idx_q == IW'(STOP_BITS - 1)) begin
                  dv_d    = 1'b1;
                  data_d  = shift_q;
                  pe_d    = perr_q;
                  fe_d    = ferr_q | ~bit_s;
                  par_d   = 1'b0;
                  perr_d  = 1'b0;
                  ferr_d  = 1'b0;
                  idx_d   = '0;
                  state_d = (ferr_q | ~bit_s) ? S_BREAK : S_IDLE;
               end else begin
                  ferr_d = ferr_q | ~bit_s;
                  idx_d  = idx_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_BREAK: begin
            if (line_q) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q  <= 1'b1;
         line_q  <= 1'b1;
         state_q <= S_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         perr_q  <= 1'b0;
         ferr_q  <= 1'b0;
         dv_q    <= 1'b0;
         data_q  <= '0;
         pe_q    <= 1'b0;
         fe_q    <= 1'b0;
      end else begin
         sync_q  <= serial_data;
         line_q  <= sync_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         perr_q  <= perr_d;
         ferr_q  <= ferr_d;
         dv_q    <= dv_d;
         data_q  <= data_d;
         pe_q    <= pe_d;
         fe_q    <= fe_d;
      end
   end

   assign o_rx_dv      = dv_q;
   assign o_rx_data    = data_q;
   assign o_parity_err = pe_q;
   assign o_frame_err  = fe_q;
   assign o_busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: four configurations driven with directed and random frames,
// scored against a frame-level model of when and what the receiver decides.
module tb_uart_rx_param;

`ifdef UART_RX_MAJORITY_EN
   localparam bit MAJ = 1'b1;
`else
   localparam bit MAJ = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] ser;
   int unsigned cyc = 0;
   int         checks = 0;
   int         failures = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic       dv0, dv1, dv2, dv3;
   logic [7:0] data0, data1;
   logic [6:0] data2;
   logic [4:0] data3;
   logic       pe0, pe1, pe2, pe3, fe0, fe1, fe2, fe3, busy0, busy1, busy2, busy3;

   uart_rx_param #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u0 (
      .clk(clk), .reset(reset), .serial_data(ser[0]), .o_rx_dv(dv0), .o_rx_data(data0),
      .o_parity_err(pe0), .o_frame_err(fe0), .o_busy(busy0));
   uart_rx_param #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1)) u1 (
      .clk(clk), .reset(reset), .serial_data(ser[1]), .o_rx_dv(dv1), .o_rx_data(data1),
      .o_parity_err(pe1), .o_frame_err(fe1), .o_busy(busy1));
   uart_rx_param #(.CLKS_PER_BIT(16), .DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(2)) u2 (
      .clk(clk), .reset(reset), .serial_data(ser[2]), .o_rx_dv(dv2), .o_rx_data(data2),
      .o_parity_err(pe2), .o_frame_err(fe2), .o_busy(busy2));
   uart_rx_param #(.CLKS_PER_BIT(8), .DATA_BITS(5), .PARITY_MODE(3), .STOP_BITS(1)) u3 (
      .clk(clk), .reset(reset), .serial_data(ser[3]), .o_rx_dv(dv3), .o_rx_data(data3),
      .o_parity_err(pe3), .o_frame_err(fe3), .o_busy(busy3));

   typedef struct {
      int unsigned cyc;
      logic [8:0]  data;
      logic        pe;
      logic        fe;
   } ev_t;

   ev_t act0[$], act1[$], act2[$], act3[$], exq[$];

   always @(negedge clk) begin
      if (dv0 === 1'b1) act0.push_back('{cyc, {1'b0, data0}, pe0, fe0});
      if (dv1 === 1'b1) act1.push_back('{cyc, {1'b0, data1}, pe1, fe1});
      if (dv2 === 1'b1) act2.push_back('{cyc, {2'b0, data2}, pe2, fe2});
      if (dv3 === 1'b1) act3.push_back('{cyc, {4'b0, data3}, pe3, fe3});
   end

   function automatic int cpb_of(input int i); return (i == 3) ? 8 : 16; endfunction
   function automatic int dbits_of(input int i); return (i == 2) ? 7 : (i == 3) ? 5 : 8; endfunction
   function automatic int pm_of(input int i); return i; endfunction
   function automatic int sbits_of(input int i); return (i == 2) ? 2 : 1; endfunction

   function automatic int act_size(input int i);
      case (i)
         0: return act0.size();
         1: return act1.size();
         2: return act2.size();
         default: return act3.size();
      endcase
   endfunction

   task automatic pop_act(input int i, output ev_t a, output bit ok);
      ok = 1'b0;
      a  = '{0, 9'd0, 1'b0, 1'b0};
      case (i)
         0: if (act0.size() > 0) begin a = act0.pop_front(); ok = 1'b1; end
         1: if (act1.size() > 0) begin a = act1.pop_front(); ok = 1'b1; end
         2: if (act2.size() > 0) begin a = act2.pop_front(); ok = 1'b1; end
         default: if (act3.size() > 0) begin a = act3.pop_front(); ok = 1'b1; end
      endcase
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Drives one frame on line i. The model: frame bit b (0 = start) is decided from the
   // pin value set at cycle b*cpb + h + 1 after the falling edge; dv follows 3 cycles later.
   task automatic send(input int i, input logic [8:0] val, input bit pflip, input logic [1:0] stop_low,
                       input int glitch_k, input int stop_at, input bit keep_low, input bit expect_ev);
      int cpb, d, pm, s, h, p, n, total, ones;
      int unsigned start;
      logic frame[$];
      logic samp[$];
      ev_t  e;
      cpb = cpb_of(i); d = dbits_of(i); pm = pm_of(i); s = sbits_of(i);
      h = (cpb - 1) / 2;
      p = (pm == 1 || pm == 2) ? 1 : 0;
      n = d + p + s;
      start = 0;
      frame.push_back(1'b0);
      ones = 0;
      for (int j = 0; j < d; j++) begin
         frame.push_back(val[j]);
         ones += int'(val[j]);
      end
      if (p == 1) frame.push_back(((ones % 2) == 1) ^ (pm == 2) ^ pflip);
      for (int j = 0; j < s; j++) frame.push_back(~stop_low[j]);
      total = (stop_at > 0) ? stop_at : (n + 1) * cpb;
      for (int k = 0; k < total; k++) begin
         @(negedge clk);
         if (k == 0) start = cyc;
         ser[i] = frame[k / cpb] ^ (k == glitch_k);
      end
      if (stop_at == 0) begin
         @(negedge clk);
         ser[i] = keep_low ? 1'b0 : 1'b1;
      end
      if (expect_ev) begin
         for (int b = 0; b <= n; b++) samp.push_back(frame[b] ^ (!MAJ && glitch_k == b * cpb + h + 1));
         e.data = '0;
         for (int j = 0; j < d; j++) e.data[j] = samp[j + 1];
         ones = 0;
         for (int b = 1; b <= d + p; b++) ones += int'(samp[b]);
         e.pe = (p == 1) ? (((ones % 2) == 1) ^ (pm == 2)) : 1'b0;
         e.fe = 1'b0;
         for (int b = d + p + 1; b <= n; b++) if (samp[b] == 1'b0) e.fe = 1'b1;
         e.cyc = start + unsigned'(n * cpb + h + 4);
         exq.push_back(e);
      end
   endtask

   task automatic check_inst(input int i, input string tag);
      ev_t a, e;
      bit  ok;
      repeat (4) @(negedge clk);
      chk({tag, ".count"}, 32'(act_size(i)), 32'(exq.size()));
      while (exq.size() > 0) begin
         e = exq.pop_front();
         pop_act(i, a, ok);
         if (ok) begin
            chk({tag, ".cycle"}, a.cyc, e.cyc);
            chk({tag, ".data"}, {23'b0, a.data}, {23'b0, e.data});
            chk({tag, ".parity_err"}, {31'b0, a.pe}, {31'b0, e.pe});
            chk({tag, ".frame_err"}, {31'b0, a.fe}, {31'b0, e.fe});
         end
      end
      do pop_act(i, a, ok); while (ok);
   endtask

   initial begin
      logic [8:0] v;
      logic [1:0] sl;
      int         ri;
      reset = 1'b1;
      ser   = '1;
      repeat (3) @(negedge clk);
      chk("rst.dv", {31'b0, dv0}, 32'd0);
      chk("rst.data", {24'b0, data0}, 32'd0);
      chk("rst.parity_err", {31'b0, pe0}, 32'd0);
      chk("rst.frame_err", {31'b0, fe0}, 32'd0);
      chk("rst.busy", {28'b0, busy3, busy2, busy1, busy0}, 32'd0);
      reset = 1'b0;
      repeat (4) @(negedge clk);

      send(0, 9'h0A5, 1'b0, 2'b00, -1, 0, 1'b0, 1'b1);
      check_inst(0, "8n1_a5");
      chk("8n1_a5.hold", {24'b0, data0}, 32'h0A5);

      send(1, 9'h003, 1'b0, 2'b00, -1, 0, 1'b0, 1'b1);
      check_inst(1, "even_ok");
      send(1, 9'h003, 1'b1, 2'b00, -1, 0, 1'b0, 1'b1);
      check_inst(1, "even_bad");

      send(2, 9'h055, 1'b0, 2'b10, -1, 0, 1'b1, 1'b1);
      repeat (5 * 16) @(negedge clk);
      chk("break.busy", {31'b0, busy2}, 32'd1);
      chk("break.hold", {25'b0, data2}, 32'h55);
      check_inst(2, "break");
      ser[2] = 1'b1;
      repeat (4) @(negedge clk);
      chk("break.release", {31'b0, busy2}, 32'd0);
      send(2, 9'h012, 1'b0, 2'b00, -1, 0, 1'b0, 1'b1);
      check_inst(2, "after_break");

      @(negedge clk);
      ser[0] = 1'b0;
      repeat (3) @(negedge clk);
      chk("glitch.busy", {31'b0, busy0}, 32'd1);
      @(negedge clk);
      ser[0] = 1'b1;
      repeat (7) @(negedge clk);
      chk("glitch.idle", {31'b0, busy0}, 32'd0);
      check_inst(0, "glitch");

      send(0, 9'h0FF, 1'b0, 2'b00, -1, 4 * 16 + 8, 1'b0, 1'b0);
      chk("abort.busy_before", {31'b0, busy0}, 32'd1);
      @(negedge clk);
      reset  = 1'b1;
      ser[0] = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("abort.busy", {31'b0, busy0}, 32'd0);
      chk("abort.outs", {22'b0, dv0, data0, pe0, fe0}, 32'd0);
      repeat (20) @(negedge clk);
      check_inst(0, "abort");
      send(0, 9'h03C, 1'b0, 2'b00, -1, 0, 1'b0, 1'b1);
      check_inst(0, "post_abort");

      send(0, 9'h000, 1'b0, 2'b00, 3 * 16 + 7 + 1, 0, 1'b0, 1'b1);
      check_inst(0, "midbit_glitch");

      send(0, 9'h05A, 1'b0, 2'b00, -1, 7 + 2 + 9 * 16, 1'b0, 1'b1);
      send(0, 9'h0C3, 1'b0, 2'b00, -1, 0, 1'b0, 1'b1);
      check_inst(0, "back_to_back");

      for (int r = 0; r < 8; r++) begin
         ri = int'($urandom_range(1, 3));
         v  = 9'($urandom);
         sl = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         send(ri, v, 1'($urandom_range(0, 1)), sl, -1, 0, 1'b0, 1'b1);
         check_inst(ri, "random");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
